// File: rtl/mmio_req_buffer_pkg.sv
// rtl/mmio_req_buffer_pkg.sv - shared types and constants for the MMIO request buffer
package mmio_req_buffer_pkg;

  typedef logic [63:0] t_mmio_value;
  typedef logic [15:0] t_csr_idx;

  // One buffered host request; rd and wr are never both set once stored
  typedef struct packed {
    t_csr_idx    addr;
    logic        rd;
    logic        wr;
    t_mmio_value data;
    logic [7:0]  be;
  } t_mmio_req;

  localparam logic [15:0] TORTURE_SEED = 16'hFFFE;

endpackage

// File: rtl/mmio_req_fifo.sv
// rtl/mmio_req_fifo.sv - in-order request FIFO with wrap-bit pointers
module mmio_req_fifo
  import mmio_req_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  t_mmio_req                push_data,
  input  logic                     pop,
  output t_mmio_req                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  t_mmio_req mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Same index with opposite wrap bits means every slot is occupied
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer advance; reset discards all stored requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mmio_req_buffer.sv
// rtl/mmio_req_buffer.sv - host MMIO request buffer; MMIO_REQ_BUF_TORTURE_EN adds a rotating waitrequest pattern
module mmio_req_buffer
  import mmio_req_buffer_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 64,
  parameter int REQ_DEPTH    = 8,
  parameter int RD_LATENCY   = 2,
  parameter int MAX_RD_OUTST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   h_address,
  input  logic                h_read,
  input  logic                h_write,
  input  logic [DATA_W-1:0]   h_writedata,
  input  logic [DATA_W/8-1:0] h_byteenable,
  output logic                h_waitrequest,
  output logic [DATA_W-1:0]   h_readdata,
  output logic                h_readdatavalid,
  output logic [ADDR_W-1:0]   d_address,
  output logic                d_read,
  output logic                d_write,
  output logic [DATA_W-1:0]   d_writedata,
  output logic [DATA_W/8-1:0] d_byteenable,
  input  logic [DATA_W-1:0]   d_readdata,
  output logic                err_rdwr
);

  localparam int CW = $clog2(REQ_DEPTH) + 1;
  // One spare count value so rd_outst + pending d_read cannot wrap
  localparam int OW = $clog2(MAX_RD_OUTST + 2);

  t_mmio_req             push_req;
  t_mmio_req             head;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         fifo_count;
  logic                  accept;
  logic                  pop;
  logic                  rd_room;
  logic [OW-1:0]         rd_outst;
  logic [RD_LATENCY-1:0] vpipe;
  logic                  fifo_full_wait;

  assign fifo_full_wait = (fifo_count == CW'(REQ_DEPTH));

`ifdef MMIO_REQ_BUF_TORTURE_EN
  logic [15:0] torture_pat;

  // Rotating stall pattern that forces the host through its retry path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) torture_pat <= TORTURE_SEED;
    else       torture_pat <= {torture_pat[14:0], torture_pat[15]};
  end

  assign h_waitrequest = fifo_full_wait | reset | torture_pat[0];
`else
  assign h_waitrequest = fifo_full_wait | reset;
`endif

  assign accept = (h_read || h_write) && !h_waitrequest;

  // Build the FIFO entry; a simultaneous read+write is kept as a read only
  always_comb begin
    push_req      = '0;
    push_req.addr = h_address;
    push_req.rd   = h_read;
    push_req.wr   = h_write && !h_read;
    push_req.data = h_writedata;
    push_req.be   = h_byteenable;
  end

  mmio_req_fifo #(.DEPTH(REQ_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (accept && !full),
    .push_data (push_req),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  // A read already on d_read is counted now so back-to-back issue cannot overshoot
  assign rd_room = (rd_outst + OW'(d_read)) < OW'(MAX_RD_OUTST);
  assign pop     = !empty && (head.wr || rd_room);

  // Drive the popped entry to the decode stage; strobes last one cycle, payload holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_read       <= 1'b0;
      d_write      <= 1'b0;
      d_address    <= '0;
      d_writedata  <= '0;
      d_byteenable <= '0;
    end else begin
      d_read  <= pop && head.rd;
      d_write <= pop && head.wr;
      if (pop) begin
        d_address    <= head.addr;
        d_writedata  <= head.data;
        d_byteenable <= head.be;
      end
    end
  end

  // Valid pipe matched to the decode-stage read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= d_read;
      for (int i = 1; i < RD_LATENCY; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  assign h_readdatavalid = vpipe[RD_LATENCY-1];
  assign h_readdata      = h_readdatavalid ? d_readdata : '0;

  // Reads in flight downstream: counted on d_read, retired on readdatavalid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_outst <= '0;
    end else if (d_read && !h_readdatavalid) begin
      rd_outst <= rd_outst + OW'(1);
    end else if (!d_read && h_readdatavalid) begin
      rd_outst <= rd_outst - OW'(1);
    end
  end

  // Sticky flag for a host cycle that asserted read and write together
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          err_rdwr <= 1'b0;
    else if (accept && h_read && h_write) err_rdwr <= 1'b1;
  end

endmodule

// File: tb/tb_mmio_req_buffer.sv
// tb/tb_mmio_req_buffer.sv - scoreboard bench for mmio_req_buffer; MMIO_REQ_BUF_TORTURE_EN adds the pattern check
module tb_mmio_req_buffer;
  import mmio_req_buffer_pkg::*;

  localparam int RDL = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] h_address = '0;
  logic        h_read = 1'b0;
  logic        h_write = 1'b0;
  logic [63:0] h_writedata = '0;
  logic [7:0]  h_byteenable = '0;
  logic        h_waitrequest;
  logic [63:0] h_readdata;
  logic        h_readdatavalid;
  logic [15:0] d_address;
  logic        d_read;
  logic        d_write;
  logic [63:0] d_writedata;
  logic [7:0]  d_byteenable;
  logic [63:0] d_readdata = '0;
  logic        err_rdwr;

  mmio_req_buffer #(
    .ADDR_W(16), .DATA_W(64), .REQ_DEPTH(8), .RD_LATENCY(RDL), .MAX_RD_OUTST(4)
  ) dut (
    .clk(clk), .reset(reset), .h_address(h_address), .h_read(h_read), .h_write(h_write),
    .h_writedata(h_writedata), .h_byteenable(h_byteenable), .h_waitrequest(h_waitrequest),
    .h_readdata(h_readdata), .h_readdatavalid(h_readdatavalid), .d_address(d_address),
    .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_readdata(d_readdata), .err_rdwr(err_rdwr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_valid = 0;
  int inflight = 0;
  int max_inflight = 0;

  t_mmio_req   exp_d[$];
  logic [63:0] exp_rd[$];
  logic [63:0] host_mem[logic [15:0]];
  logic [63:0] dec_mem[logic [15:0]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] init_val(input logic [15:0] a);
    return (a == 16'h0001) ? 64'hA5A5 : {32'hC0DE_0000, 16'h0000, a};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] be);
    logic [63:0] r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] host_rd(input logic [15:0] a);
    return host_mem.exists(a) ? host_mem[a] : init_val(a);
  endfunction

  function automatic logic [63:0] dec_rd(input logic [15:0] a);
    return dec_mem.exists(a) ? dec_mem[a] : init_val(a);
  endfunction

  // Decode-stage model: data captured at d_read, presented RDL cycles later
  logic        sh_v[RDL+1];
  logic [63:0] sh_d[RDL+1];
  initial begin
    for (int i = 0; i <= RDL; i++) begin sh_v[i] = 1'b0; sh_d[i] = '0; end
    forever begin
      @(posedge clk); #1;
      for (int i = RDL; i > 0; i--) begin sh_v[i] = sh_v[i-1]; sh_d[i] = sh_d[i-1]; end
      sh_v[0] = d_read;
      sh_d[0] = d_read ? dec_rd(d_address) : 64'h0;
      if (d_write) dec_mem[d_address] = merge(dec_rd(d_address), d_writedata, d_byteenable);
      d_readdata = sh_v[RDL] ? sh_d[RDL] : 64'h0;
    end
  end

  // Output monitor: pops the scoreboard on every issue and every returned read
  initial begin
    t_mmio_req e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (h_readdatavalid) begin
          n_valid++;
          inflight--;
          if (exp_rd.size() == 0) check("unexp_valid", 1, 0);
          else check("rd_data", h_readdata, exp_rd.pop_front());
        end
        if (d_read) begin
          inflight++;
          if (inflight > max_inflight) max_inflight = inflight;
        end
        if (d_read || d_write) begin
          if (exp_d.size() == 0) begin
            check("unexp_issue", {d_read, d_write}, 0);
          end else begin
            e = exp_d.pop_front();
            check("d_read", d_read, e.rd);
            check("d_write", d_write, e.wr);
            check("d_address", d_address, e.addr);
            if (e.wr) begin
              check("d_writedata", d_writedata, e.data);
              check("d_byteenable", d_byteenable, e.be);
            end
          end
        end
      end
    end
  end

  task automatic host_req(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [63:0] d, input logic [7:0] be);
    t_mmio_req e;
    bit ok = 0;
    h_read = rd; h_write = wr; h_address = a; h_writedata = d; h_byteenable = be;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (!h_waitrequest) begin
        ok = 1;
        n_acc++;
        e.addr = a; e.rd = rd; e.wr = wr && !rd; e.data = d; e.be = be;
        exp_d.push_back(e);
        if (rd) exp_rd.push_back(host_rd(a));
        else    host_mem[a] = merge(host_rd(a), d, be);
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    h_read = 1'b0; h_write = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((exp_d.size() != 0 || exp_rd.size() != 0) && t < 300) begin
      @(negedge clk); t++;
    end
    check(tag, exp_d.size() + exp_rd.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_d.delete(); exp_rd.delete();
    inflight = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int rd_cyc, v_cyc, nrd, base_acc, base_valid;
    logic [63:0] vdata;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_waitreq", h_waitrequest, 1);
    check("rst_outs", {h_readdatavalid, d_read, d_write, err_rdwr}, 0);
    check("rst_addr_data", {d_address, d_byteenable, h_readdata[15:0]}, 0);
    @(posedge clk); #1 reset = 1'b0;

`ifdef MMIO_REQ_BUF_TORTURE_EN
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("torture_pat", h_waitrequest, (i == 0) ? 1'b0 : 1'b1);
    end
    @(posedge clk); #1;
`endif

    // 1: single read latency and data
    host_req(1, 0, 16'h0001, 64'h0, 8'h00);
    rd_cyc = -1; v_cyc = -1; nrd = 0; vdata = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (d_read) begin nrd++; if (rd_cyc < 0) rd_cyc = k; end
      if (h_readdatavalid && v_cyc < 0) begin v_cyc = k; vdata = h_readdata; end
    end
    check("t1_dread_cyc", rd_cyc, 2);
    check("t1_dread_len", nrd, 1);
    check("t1_valid_cyc", v_cyc, 4);
    check("t1_data", vdata, 64'hA5A5);
    drain("t1_drain");

    // 2: fill the FIFO behind a stalled read
    base_acc = n_acc;
    force dut.rd_outst = 3'd4;
    fork
      begin
        host_req(1, 0, 16'h0040, 64'h0, 8'h00);
        for (int i = 0; i < 10; i++)
          host_req(0, 1, 16'h0100 + 16'(i), 64'hB000 + 64'(i), 8'hFF);
      end
      begin
        for (int t = 0; t < 300 && n_acc < base_acc + 8; t++) @(negedge clk);
        @(negedge clk);
        check("t2_waitreq_full", h_waitrequest, 1);
        check("t2_count", dut.u_fifo.count, 8);
        repeat (4) @(negedge clk);
        check("t2_still_full", h_waitrequest, 1);
        @(posedge clk); #1;
        force dut.rd_outst = 3'd0;
        release dut.rd_outst;
      end
    join
    drain("t2_drain");

    // 3: six back-to-back reads
    max_inflight = 0;
    base_valid = n_valid;
    for (int i = 0; i < 6; i++) host_req(1, 0, 16'h0050 + 16'(i), 64'h0, 8'h00);
    drain("t3_drain");
    repeat (3) @(negedge clk);
    check("t3_max_outst", (max_inflight <= 4), 1);
    check("t3_nvalid", n_valid - base_valid, 6);
    check("t3_outst_zero", dut.rd_outst, 0);
    @(posedge clk); #1;

    // 4: read, partial write, read back
    host_req(1, 0, 16'h0020, 64'h0, 8'h00);
    host_req(0, 1, 16'h0020, 64'h1234, 8'h03);
    host_req(1, 0, 16'h0020, 64'h0, 8'h00);
    drain("t4_drain");
    check("t4_model", host_rd(16'h0020), {32'hC0DE_0000, 32'h0000_1234});

    // 5: reset with reads in flight
    base_valid = n_valid;
    for (int i = 0; i < 3; i++) host_req(1, 0, 16'h0060 + 16'(i), 64'h0, 8'h00);
    reset = 1'b1;
    exp_d.delete(); exp_rd.delete();
    inflight = 0;
    @(negedge clk);
    check("t5_waitreq_rst", h_waitrequest, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_no_valid", n_valid - base_valid, 0);
    check("t5_fifo_empty", dut.u_fifo.empty, 1);
    check("t5_outst_zero", dut.rd_outst, 0);
    @(posedge clk); #1;

    // 6: read and write together
    check("t6_err_clear", err_rdwr, 0);
    host_req(1, 1, 16'h0030, 64'hDEAD, 8'hFF);
    drain("t6_drain");
    check("t6_err_set", err_rdwr, 1);
    repeat (5) @(negedge clk);
    check("t6_err_sticky", err_rdwr, 1);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("t6_err_reset", err_rdwr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
